// File: rtl/conv_addr_gen.sv
// Convolution address generator: walks oy, ox, ky, kx, ct and emits IFM/filter
// word addresses with pad flag over a valid/ready stream.
`timescale 1ns/1ps
module conv_addr_gen #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DIM_W      = 8,
   parameter int unsigned TILE_C     = 4,
   parameter int unsigned WORD_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_ifm_base,
   input  logic [ADDR_W-1:0] cfg_flt_base,
   input  logic [DIM_W-1:0]  cfg_ifm_w,
   input  logic [DIM_W-1:0]  cfg_ifm_h,
   input  logic [DIM_W-1:0]  cfg_ifm_c,
   input  logic [DIM_W-1:0]  cfg_ofm_w,
   input  logic [DIM_W-1:0]  cfg_ofm_h,
   input  logic [3:0]        cfg_kernel,
   input  logic [1:0]        cfg_stride,
   input  logic [1:0]        cfg_pad,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic [ADDR_W-1:0] ifm_addr,
   output logic              ifm_pad,
   output logic [ADDR_W-1:0] flt_addr,
   output logic              win_last,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);
   localparam int unsigned SW = DIM_W + 3;
   localparam int unsigned CW = DIM_W + 1;

   typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ifm_base_q, ifm_base_d, flt_base_q, flt_base_d;
   logic [DIM_W-1:0]  ifm_w_q, ifm_w_d, ifm_h_q, ifm_h_d, ifm_c_q, ifm_c_d;
   logic [DIM_W-1:0]  ofm_w_q, ofm_w_d, ofm_h_q, ofm_h_d;
   logic [3:0]        k_q, k_d;
   logic [1:0]        s_q, s_d, p_q, p_d;
   logic [DIM_W-1:0]  oy_q, oy_d, ox_q, ox_d, ct_q, ct_d;
   logic [3:0]        ky_q, ky_d, kx_q, kx_d;
   logic              valid_q, valid_d, pad_q, pad_d, last_q, last_d;
   logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d, flt_addr_q, flt_addr_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [CW-1:0]     ct_round;
   logic [DIM_W-1:0]  ct_tiles, ct_last;
   logic [3:0]        k_last;
   logic              load;
   logic [SW-1:0]     iy, ix;
   logic              pad_n;
   logic [ADDR_W-1:0] pix_idx, ifm_word, flt_word;

   // Tile count rounds channels up to whole memory words.
   always_comb begin
      ct_round = CW'(ifm_c_q) + CW'(TILE_C - 1);
      ct_tiles = DIM_W'(ct_round / CW'(TILE_C));
      ct_last  = ct_tiles - DIM_W'(1);
      k_last   = k_q - 4'd1;
   end

   // Next-state, counter advance and next-beat address computation.
   always_comb begin
      state_d    = state_q;
      ifm_base_d = ifm_base_q;
      flt_base_d = flt_base_q;
      ifm_w_d    = ifm_w_q;
      ifm_h_d    = ifm_h_q;
      ifm_c_d    = ifm_c_q;
      ofm_w_d    = ofm_w_q;
      ofm_h_d    = ofm_h_q;
      k_d        = k_q;
      s_d        = s_q;
      p_d        = p_q;
      oy_d       = oy_q;
      ox_d       = ox_q;
      ky_d       = ky_q;
      kx_d       = kx_q;
      ct_d       = ct_q;
      valid_d    = valid_q;
      pad_d      = pad_q;
      last_d     = last_q;
      ifm_addr_d = ifm_addr_q;
      flt_addr_d = flt_addr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               ifm_base_d = cfg_ifm_base;
               flt_base_d = cfg_flt_base;
               ifm_w_d    = cfg_ifm_w;
               ifm_h_d    = cfg_ifm_h;
               ifm_c_d    = cfg_ifm_c;
               ofm_w_d    = cfg_ofm_w;
               ofm_h_d    = cfg_ofm_h;
               k_d        = cfg_kernel;
               s_d        = cfg_stride;
               p_d        = cfg_pad;
               err_d      = 1'b0;
               busy_d     = 1'b1;
               state_d    = CHECK;
            end
         end
         CHECK: begin
            if (k_q == 4'd0 || s_q == 2'd0 || ifm_c_q == '0 ||
                ofm_w_q == '0 || ofm_h_q == '0) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = FIN;
            end else begin
               oy_d    = '0;
               ox_d    = '0;
               ky_d    = '0;
               kx_d    = '0;
               ct_d    = '0;
               valid_d = 1'b1;
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (valid_q && addr_ready) begin
               if (last_q && oy_q == ofm_h_q - DIM_W'(1) &&
                   ox_q == ofm_w_q - DIM_W'(1)) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  load = 1'b1;
                  if (ct_q != ct_last) begin
                     ct_d = ct_q + DIM_W'(1);
                  end else begin
                     ct_d = '0;
                     if (kx_q != k_last) begin
                        kx_d = kx_q + 4'd1;
                     end else begin
                        kx_d = '0;
                        if (ky_q != k_last) begin
                           ky_d = ky_q + 4'd1;
                        end else begin
                           ky_d = '0;
                           if (ox_q != ofm_w_q - DIM_W'(1)) begin
                              ox_d = ox_q + DIM_W'(1);
                           end else begin
                              ox_d = '0;
                              oy_d = oy_q + DIM_W'(1);
                           end
                        end
                     end
                  end
               end
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Addresses for the beat that will be presented after this edge.
      iy       = SW'(oy_d) * SW'(s_q) + SW'(ky_d) - SW'(p_q);
      ix       = SW'(ox_d) * SW'(s_q) + SW'(kx_d) - SW'(p_q);
      pad_n    = iy[SW-1] || ix[SW-1] || (iy >= SW'(ifm_h_q)) || (ix >= SW'(ifm_w_q));
      pix_idx  = ADDR_W'(iy) * ADDR_W'(ifm_w_q) + ADDR_W'(ix);
      ifm_word = pix_idx * ADDR_W'(ct_tiles) + ADDR_W'(ct_d);
      flt_word = (ADDR_W'(ky_d) * ADDR_W'(k_q) + ADDR_W'(kx_d)) * ADDR_W'(ct_tiles)
                 + ADDR_W'(ct_d);
      if (load) begin
         pad_d      = pad_n;
         ifm_addr_d = pad_n ? '0 : ifm_base_q + ifm_word * ADDR_W'(WORD_BYTES);
         flt_addr_d = flt_base_q + flt_word * ADDR_W'(WORD_BYTES);
         last_d     = (ky_d == k_last) && (kx_d == k_last) && (ct_d == ct_last);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ifm_base_q <= '0;
         flt_base_q <= '0;
         ifm_w_q    <= '0;
         ifm_h_q    <= '0;
         ifm_c_q    <= '0;
         ofm_w_q    <= '0;
         ofm_h_q    <= '0;
         k_q        <= '0;
         s_q        <= '0;
         p_q        <= '0;
         oy_q       <= '0;
         ox_q       <= '0;
         ky_q       <= '0;
         kx_q       <= '0;
         ct_q       <= '0;
         valid_q    <= 1'b0;
         pad_q      <= 1'b0;
         last_q     <= 1'b0;
         ifm_addr_q <= '0;
         flt_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ifm_base_q <= ifm_base_d;
         flt_base_q <= flt_base_d;
         ifm_w_q    <= ifm_w_d;
         ifm_h_q    <= ifm_h_d;
         ifm_c_q    <= ifm_c_d;
         ofm_w_q    <= ofm_w_d;
         ofm_h_q    <= ofm_h_d;
         k_q        <= k_d;
         s_q        <= s_d;
         p_q        <= p_d;
         oy_q       <= oy_d;
         ox_q       <= ox_d;
         ky_q       <= ky_d;
         kx_q       <= kx_d;
         ct_q       <= ct_d;
         valid_q    <= valid_d;
         pad_q      <= pad_d;
         last_q     <= last_d;
         ifm_addr_q <= ifm_addr_d;
         flt_addr_q <= flt_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign addr_valid = valid_q;
   assign ifm_addr   = ifm_addr_q;
   assign ifm_pad    = pad_q;
   assign flt_addr   = flt_addr_q;
   assign win_last   = last_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = err_q;
endmodule

// File: tb/tb_conv_addr_gen.sv
// Bench for conv_addr_gen: reference model fills an expected-beat queue that is
// drained against DUT transfers, plus latency, handshake, error and reset cases.
`timescale 1ns/1ps
module tb_conv_addr_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cfg_ifm_base = '0, cfg_flt_base = '0;
   logic [7:0]  cfg_ifm_w = '0, cfg_ifm_h = '0, cfg_ifm_c = '0, cfg_ofm_w = '0, cfg_ofm_h = '0;
   logic [3:0]  cfg_kernel = '0;
   logic [1:0]  cfg_stride = '0, cfg_pad = '0;
   logic        addr_ready = 1'b0;
   logic        addr_valid, ifm_pad, win_last, busy, done, cfg_err;
   logic [31:0] ifm_addr, flt_addr;

   conv_addr_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_ifm_base(cfg_ifm_base), .cfg_flt_base(cfg_flt_base),
      .cfg_ifm_w(cfg_ifm_w), .cfg_ifm_h(cfg_ifm_h), .cfg_ifm_c(cfg_ifm_c),
      .cfg_ofm_w(cfg_ofm_w), .cfg_ofm_h(cfg_ofm_h),
      .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride), .cfg_pad(cfg_pad),
      .addr_valid(addr_valid), .addr_ready(addr_ready),
      .ifm_addr(ifm_addr), .ifm_pad(ifm_pad), .flt_addr(flt_addr),
      .win_last(win_last), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] ifm;
      logic        pad;
      logic [31:0] flt;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] got_ifm[$];
   logic [31:0] got_flt[$];
   logic        got_pad[$];
   logic        got_last[$];
   int          checks = 0;
   int          failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_cfg(input int iw, input int ih, input int ic, input int ow, input int oh,
                          input int k, input int s, input int p);
      cfg_ifm_w  = 8'(iw);
      cfg_ifm_h  = 8'(ih);
      cfg_ifm_c  = 8'(ic);
      cfg_ofm_w  = 8'(ow);
      cfg_ofm_h  = 8'(oh);
      cfg_kernel = 4'(k);
      cfg_stride = 2'(s);
      cfg_pad    = 2'(p);
   endtask

   // Reference model straight from the address formulas.
   task automatic push_model();
      int    ctn, k, iy, ix;
      beat_t b;
      ctn = (int'(cfg_ifm_c) + 3) / 4;
      k   = int'(cfg_kernel);
      for (int oy = 0; oy < int'(cfg_ofm_h); oy++)
         for (int ox = 0; ox < int'(cfg_ofm_w); ox++)
            for (int ky = 0; ky < k; ky++)
               for (int kx = 0; kx < k; kx++)
                  for (int c = 0; c < ctn; c++) begin
                     iy     = oy * int'(cfg_stride) + ky - int'(cfg_pad);
                     ix     = ox * int'(cfg_stride) + kx - int'(cfg_pad);
                     b.pad  = (iy < 0) || (iy >= int'(cfg_ifm_h)) || (ix < 0) || (ix >= int'(cfg_ifm_w));
                     b.ifm  = b.pad ? 32'd0 : cfg_ifm_base + 32'(((iy * int'(cfg_ifm_w) + ix) * ctn + c) * 4);
                     b.flt  = cfg_flt_base + 32'(((ky * k + kx) * ctn + c) * 4);
                     b.last = (ky == k - 1) && (kx == k - 1) && (c == ctn - 1);
                     exp_q.push_back(b);
                  end
   endtask

   // Runs one layer; ready_mode 1 randomises ready, abort_at >= 0 resets after that many beats.
   task automatic run_layer(input int ready_mode, input int abort_at, input int exp_beats,
                            input logic exp_err);
      int          n;
      logic        r, have_hold, fin;
      logic [31:0] h_ifm;
      logic [33:0] h_rest;
      beat_t       b;
      exp_q.delete();
      got_ifm.delete();
      got_flt.delete();
      got_pad.delete();
      got_last.delete();
      n = 0;
      have_hold = 1'b0;
      fin = 1'b0;
      @(negedge clk);
      start = 1'b1;
      push_model();
      @(negedge clk);
      start = 1'b0;
      check_eq("lat_valid_c1", 64'(addr_valid), 64'd0);
      check_eq("lat_busy_c1", 64'(busy), 64'd1);
      check_eq("err_clr_on_start", 64'(cfg_err), 64'd0);
      for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
         @(negedge clk);
         start = (ready_mode == 1 && cyc == 10);
         if (have_hold) begin
            check_eq("hold_valid", 64'(addr_valid), 64'd1);
            check_eq("hold_ifm", 64'(ifm_addr), 64'(h_ifm));
            check_eq("hold_rest", 64'({ifm_pad, win_last, flt_addr}), 64'(h_rest));
            have_hold = 1'b0;
         end
         if (cyc == 0 && !exp_err) check_eq("lat_valid_c2", 64'(addr_valid), 64'd1);
         if (abort_at >= 0 && n == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_eq("abort_outs", 64'({addr_valid, ifm_pad, win_last, busy, done, cfg_err}), 64'd0);
            check_eq("abort_addrs", {ifm_addr, flt_addr}, 64'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) begin
               @(negedge clk);
               check_eq("abort_no_done", 64'({done, addr_valid, busy}), 64'd0);
            end
            exp_q.delete();
            fin = 1'b1;
         end else if (done) begin
            if (exp_err) check_eq("err_done_cycle", 64'(cyc), 64'd0);
            check_eq("done_valid_low", 64'(addr_valid), 64'd0);
            check_eq("beats_total", 64'(n), 64'(exp_beats));
            check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
            check_eq("cfg_err_at_done", 64'(cfg_err), 64'(exp_err));
            @(negedge clk);
            check_eq("post_done", 64'({busy, done, addr_valid}), 64'd0);
            check_eq("cfg_err_sticky", 64'(cfg_err), 64'(exp_err));
            fin = 1'b1;
         end else begin
            r = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            addr_ready = r;
            if (!addr_valid && cyc > 0 && exp_q.size() > 0)
               check_eq("no_bubble", 64'(addr_valid), 64'd1);
            if (addr_valid && r) begin
               if (exp_q.size() == 0) begin
                  check_eq("extra_beat", 64'd1, 64'd0);
               end else begin
                  b = exp_q.pop_front();
                  check_eq("beat_ifm", 64'(ifm_addr), 64'(b.ifm));
                  check_eq("beat_flt", 64'(flt_addr), 64'(b.flt));
                  check_eq("beat_pad_last", 64'({ifm_pad, win_last}), 64'({b.pad, b.last}));
               end
               got_ifm.push_back(ifm_addr);
               got_flt.push_back(flt_addr);
               got_pad.push_back(ifm_pad);
               got_last.push_back(win_last);
               n++;
            end else if (addr_valid) begin
               have_hold = 1'b1;
               h_ifm     = ifm_addr;
               h_rest    = {ifm_pad, win_last, flt_addr};
            end
         end
      end
      if (!fin) check_eq("timeout", 64'd0, 64'd1);
      start = 1'b0;
      addr_ready = 1'b0;
   endtask

   function automatic int count_pads();
      int c = 0;
      foreach (got_pad[i]) if (got_pad[i]) c++;
      return c;
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_outs", 64'({addr_valid, ifm_pad, win_last, busy, done, cfg_err}), 64'd0);
      check_eq("rst_addrs", {ifm_addr, flt_addr}, 64'd0);
      rst_n = 1'b1;

      // Case 1: basic 4x4x8, K3 S1 P0
      cfg_ifm_base = 32'h1000;
      cfg_flt_base = 32'h2000;
      set_cfg(4, 4, 8, 2, 2, 3, 1, 0);
      run_layer(0, -1, 72, 1'b0);
      if (got_ifm.size() == 72) begin
         check_eq("c1_b0", 64'(got_ifm[0]), 64'h1000);
         check_eq("c1_b1", 64'(got_ifm[1]), 64'h1004);
         check_eq("c1_b2", 64'(got_ifm[2]), 64'h1008);
         check_eq("c1_ky1", 64'(got_ifm[6]), 64'h1020);
         check_eq("c1_last_addr", 64'(got_ifm[17]), 64'h1054);
         check_eq("c1_last_flag", 64'(got_last[17]), 64'd1);
         check_eq("c1_win1", 64'(got_ifm[18]), 64'h1008);
         check_eq("c1_flt_end", 64'(got_flt[35]), 64'h2044);
         check_eq("c1_flt_rst", 64'(got_flt[36]), 64'h2000);
      end else check_eq("c1_count", 64'(got_ifm.size()), 64'd72);

      // Case 2: padding
      set_cfg(4, 4, 4, 4, 4, 3, 1, 1);
      run_layer(0, -1, 144, 1'b0);
      if (got_ifm.size() == 144) begin
         check_eq("c2_pad0_3", 64'({got_pad[0], got_pad[1], got_pad[2], got_pad[3]}), 64'hF);
         check_eq("c2_pad_addr0", 64'(got_ifm[0]), 64'd0);
         check_eq("c2_b4", 64'({got_pad[4], got_ifm[4]}), 64'h1000);
         check_eq("c2_b6", 64'({got_pad[6], got_ifm[6]}), 64'h1_0000_0000);
         check_eq("c2_pad_total", 64'(count_pads()), 64'd44);
      end else check_eq("c2_count", 64'(got_ifm.size()), 64'd144);

      // Case 3: stride 2
      set_cfg(5, 5, 4, 2, 2, 3, 2, 0);
      run_layer(0, -1, 36, 1'b0);
      if (got_ifm.size() == 36) begin
         check_eq("c3_win01", 64'(got_ifm[9]), 64'h1008);
         check_eq("c3_win10", 64'(got_ifm[18]), 64'h1028);
      end else check_eq("c3_count", 64'(got_ifm.size()), 64'd36);

      // Case 4: case 1 with random back-pressure and a start while busy
      set_cfg(4, 4, 8, 2, 2, 3, 1, 0);
      run_layer(1, -1, 72, 1'b0);

      // Case 5: K=0 config error, then a valid layer clears it
      set_cfg(4, 4, 8, 2, 2, 0, 1, 0);
      run_layer(0, -1, 0, 1'b1);
      set_cfg(4, 4, 8, 2, 2, 3, 1, 0);
      run_layer(0, -1, 72, 1'b0);

      // Case 6: reset mid-layer, then full rerun
      run_layer(0, 30, 72, 1'b0);
      run_layer(0, -1, 72, 1'b0);
      if (got_ifm.size() == 72)
         check_eq("c6_rerun_b0", 64'({got_ifm[0], got_flt[0]}), 64'h0000_1000_0000_2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv_addr_gen.md
Name: conv_addr_gen

Overview:
- Parametrised address generator for the fused-block CNN datapath.
- Walks every output pixel of a convolution layer; per pixel walks kernel rows, kernel columns, then IFM channel tiles.
- Each step emits one IFM word address plus a matching filter word address.
- Adds to the previous generation: stride, zero-padding with a pad flag, non-square IFM/OFM, a valid/ready back-pressure handshake, a config-error path and a done pulse.

Parameters:
- ADDR_W, 32, width of base and output addresses.
- DIM_W, 8, width of spatial and channel config fields.
- TILE_C, 4, channels packed per memory word (power of 2).
- WORD_BYTES, 4, byte stride between consecutive words.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a layer; ignored unless IDLE.
- cfg_ifm_base  in  ADDR_W  IFM byte base address.
- cfg_flt_base  in  ADDR_W  filter byte base address.
- cfg_ifm_w, cfg_ifm_h, cfg_ifm_c  in  DIM_W each  IFM width, height, channels.
- cfg_ofm_w, cfg_ofm_h  in  DIM_W each  OFM width, height.
- cfg_kernel  in  4  kernel size K (KxK).
- cfg_stride  in  2  stride S.
- cfg_pad  in  2  symmetric zero-pad P.
- addr_valid  out  1  beat on the address outputs is valid.
- addr_ready  in  1  consumer accepts the beat.
- ifm_addr  out  ADDR_W  IFM word address; 0 when ifm_pad=1.
- ifm_pad  out  1  beat lies in the padding region; consumer substitutes zeros.
- flt_addr  out  ADDR_W  filter word address.
- win_last  out  1  last beat of the current output pixel.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of layer.
- cfg_err  out  1  sticky error flag; cleared on next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-layer aborts immediately; no done pulse is issued.
- States:
  - IDLE: on start, latch all cfg_* and go to CHECK.
  - CHECK (1 cycle): if K==0, S==0, cfg_ifm_c==0, cfg_ofm_w==0 or cfg_ofm_h==0, set cfg_err and go to FIN. Otherwise go to RUN.
  - RUN: emit beats.
  - FIN: pulse done for 1 cycle, then go to IDLE.
  - busy=1 in CHECK, RUN and FIN.
- Latency: first addr_valid appears 2 cycles after the start cycle (start at cycle 0 -> valid at cycle 2).
- Tiles: CT = ceil(cfg_ifm_c / TILE_C).
- Loop order, outermost to innermost: oy, ox, ky, kx, ct.
- Beats per layer: OFM_H*OFM_W*K*K*CT.
- Per-beat IFM coordinates, computed as signed DIM_W+3-bit values:
  - iy = oy*S + ky - P
  - ix = ox*S + kx - P
  - ifm_pad = (iy<0) | (iy>=IFM_H) | (ix<0) | (ix>=IFM_W)
- ifm_addr = cfg_ifm_base + ((iy*IFM_W + ix)*CT + ct)*WORD_BYTES, modulo 2^ADDR_W.
- flt_addr = cfg_flt_base + ((ky*K + kx)*CT + ct)*WORD_BYTES. It restarts at cfg_flt_base for every output pixel.
- win_last = 1 when ky=K-1, kx=K-1 and ct=CT-1.
- Outputs are registered. Addresses may be built with incremental adders or multipliers, but one new beat per cycle must be sustainable.
- Handshake:
  - A beat transfers when addr_valid & addr_ready.
  - While addr_valid & !addr_ready, every output holds stable.
  - addr_valid never drops without a transfer, except on reset.
  - With addr_ready held high, there are no bubbles between beats, including across window boundaries.
- End of layer: after the final beat transfers, addr_valid goes low next cycle and the FSM enters FIN. done pulses that cycle; busy drops the cycle after.
- start while busy is ignored and has no effect on the running layer.
- OFM dimensions are taken as given. Windows that extend past the IFM are treated as padding and are not an error.

Test Plan:
- 4x4x8 IFM, K=3, S=1, P=0, OFM 2x2, ifm_base 0x1000, flt_base 0x2000, ready=1 -> 72 beats, no gaps.
  - Window 0 IFM addresses: 0x1000, 0x1004, 0x1008, ...; beat (ky1,kx0,ct0)=0x1020; last beat 0x1054 with win_last=1.
  - Window 1 starts at 0x1008.
  - flt_addr runs 0x2000..0x2044 in every window.
  - done pulses once; busy low after.
- 4x4x4 IFM, K=3, S=1, P=1, OFM 4x4 -> 144 beats.
  - Window 0: beats 0-3 and beat 6 have ifm_pad=1 and ifm_addr=0; beat 4 has ifm_addr=base.
  - Total pad-flagged beats over the layer = 44.
- 5x5x4 IFM, K=3, S=2, P=0, OFM 2x2 -> window (0,1) first ifm_addr=base+0x08; window (1,0) first ifm_addr=base+0x28.
- Case 1 with addr_ready toggled pseudo-randomly -> beat sequence identical to the ready=1 run; outputs stable whenever valid=1 and ready=0.
- K=0 start -> no addr_valid, cfg_err=1, done pulse 2 cycles after start. A following valid start clears cfg_err.
- rst_n low at beat 30 of case 1 -> all outputs 0 asynchronously, no done pulse. A fresh start reproduces case 1 from beat 0.
